// File: rtl/gb_pkg.sv
// Shared definitions for the Game Boy bus fabric: memory map boundaries,
// region sizes and the region-select enum produced by the address decoder.
package gb_pkg;

  // Memory map boundaries (inclusive end for the boot window, bases elsewhere)
  localparam logic [15:0] BOOT_END     = 16'h00FF;
  localparam logic [15:0] VRAM_BASE    = 16'h8000;
  localparam logic [15:0] EXT_BASE     = 16'hA000;
  localparam logic [15:0] WRAM_BASE    = 16'hC000;
  localparam logic [15:0] ECHO_BASE    = 16'hE000;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam logic [15:0] UNUSED_BASE  = 16'hFEA0;
  localparam logic [15:0] IO_BASE      = 16'hFF00;
  localparam logic [15:0] BOOTOFF_ADDR = 16'hFF50;
  localparam logic [15:0] HRAM_BASE    = 16'hFF80;
  localparam logic [15:0] IE_ADDR      = 16'hFFFF;

  // Storage sizes in bytes
  localparam int BOOT_SIZE = 256;
  localparam int CART_SIZE = 32768;
  localparam int VRAM_SIZE = 8192;
  localparam int WRAM_SIZE = 8192;
  localparam int OAM_SIZE  = 160;
  localparam int IO_SIZE   = 128;
  localparam int HRAM_SIZE = 127;

  // Target selected by an address. REGION_BOOT is the low 256 B window whose
  // backing store (boot ROM or cartridge) depends on boot_en at the user.
  typedef enum logic [3:0] {
    REGION_BOOT,
    REGION_CART,
    REGION_VRAM,
    REGION_EXT,
    REGION_WRAM,
    REGION_OAM,
    REGION_UNUSED,
    REGION_IO,
    REGION_BOOTOFF,
    REGION_HRAM,
    REGION_IE
  } region_e;

endpackage

// File: rtl/cpu.sv
// Minimal stand-in bus master with the core's port list. It streams reads
// through the address space and keeps the last byte seen; the real core
// replaces this file without touching the fabric.
module cpu (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] addr,
  output logic [7:0]  wdata,
  input  logic [7:0]  rdata,
  output logic        rd,
  output logic        wr
);

  logic [15:0] pc_q, pc_d;
  logic [7:0]  last_q, last_d;

  // Next fetch address and captured read byte.
  always_comb begin
    pc_d   = pc_q + 16'd1;
    last_d = rdata;
  end

  // Fetch pointer and data latch.
  always_ff @(posedge clock) begin
    // NOTE: clocked state uses non-blocking (<=) so all flops sample pre-edge values together.
    if (reset) begin
      pc_q   <= 16'h0000;
      last_q <= 8'h00;
    end else begin
      pc_q   <= pc_d;
      last_q <= last_d;
    end
  end

  assign addr  = pc_q;
  assign wdata = last_q;
  assign rd    = 1'b1;
  assign wr    = 1'b0;

endmodule

// File: rtl/gb_addr_decode.sv
// Combinational address decoder: maps a 16-bit CPU-space address to a target
// region and the byte offset inside that region. Echo RAM folds onto WRAM.
module gb_addr_decode
  import gb_pkg::*;
(
  input  logic [15:0] addr,
  output region_e     region,
  output logic [14:0] offset
);

  // Priority decode, first match wins; FF50 is carved out ahead of the I/O file.
  always_comb begin
    // NOTE: every output gets a default before the if-chain so no path leaves it unassigned (no latch).
    region = REGION_UNUSED;
    offset = addr[14:0];
    if (addr <= BOOT_END) begin
      region = REGION_BOOT;
    end else if (addr < VRAM_BASE) begin
      region = REGION_CART;
    end else if (addr < EXT_BASE) begin
      region = REGION_VRAM;
      offset = {2'b00, addr[12:0]};
    end else if (addr < WRAM_BASE) begin
      region = REGION_EXT;
    end else if (addr < ECHO_BASE) begin
      region = REGION_WRAM;
      offset = {2'b00, addr[12:0]};
    end else if (addr < OAM_BASE) begin
      region = REGION_WRAM;
      offset = {2'b00, addr[12:0]};
    end else if (addr < UNUSED_BASE) begin
      region = REGION_OAM;
      offset = {7'd0, addr[7:0]};
    end else if (addr < IO_BASE) begin
      region = REGION_UNUSED;
    end else if (addr == BOOTOFF_ADDR) begin
      region = REGION_BOOTOFF;
    end else if (addr < HRAM_BASE) begin
      region = REGION_IO;
      offset = {8'd0, addr[6:0]};
    end else if (addr < IE_ADDR) begin
      region = REGION_HRAM;
      offset = {8'd0, addr[6:0]};
    end else begin
      region = REGION_IE;
    end
  end

endmodule

// File: rtl/gb_interconnect.sv
// Game Boy system bus fabric: CPU as sole master, decoded onto boot ROM,
// cartridge ROM, VRAM, WRAM/echo, OAM, I/O file, HRAM and IE. Reads have one
// cycle of latency and return pre-write contents when a write hits the same cycle.
module gb_interconnect
  import gb_pkg::*;
#(
  parameter string BOOT_ROM_FILE = "boot.hex",
  parameter string CART_ROM_FILE = "cart.hex"
) (
  input logic clock,
  input logic reset
);

  // Probe-visible bus nets
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_rd;
  logic        cpu_wr;
  logic        boot_en;

  cpu u_cpu (
    .clock (clock),
    .reset (reset),
    .addr  (cpu_addr),
    .wdata (cpu_wdata),
    .rdata (cpu_rdata),
    .rd    (cpu_rd),
    .wr    (cpu_wr)
  );

  region_e     dec_region;
  logic [14:0] dec_offset;

  gb_addr_decode u_addr_decode (
    .addr   (cpu_addr),
    .region (dec_region),
    .offset (dec_offset)
  );

  // Reset suppresses both bus directions on the edge it is asserted.
  logic rd_en, wr_en;
  assign rd_en = cpu_rd & ~reset;
  assign wr_en = cpu_wr & ~reset;

  // ---------------------------------------------------------------- memories
  logic [7:0] boot_rom [BOOT_SIZE];
  logic [7:0] cart_rom [CART_SIZE];
  logic [7:0] vram     [VRAM_SIZE];
  logic [7:0] wram     [WRAM_SIZE];
  logic [7:0] oam      [OAM_SIZE];
  logic [7:0] hram     [HRAM_SIZE];

  logic [7:0] boot_rd_q, cart_rd_q, vram_rd_q, wram_rd_q, oam_rd_q, hram_rd_q;

  // ROM read ports; the boot window also reads the cart at the same offset.
  always_ff @(posedge clock) begin
    if (rd_en) begin
      boot_rd_q <= boot_rom[dec_offset[7:0]];
      cart_rd_q <= cart_rom[dec_offset];
    end
  end

  // VRAM synchronous RAM.
  always_ff @(posedge clock) begin
    // NOTE: RAM arrays and their read registers have no reset so they map to block RAM; contents survive reset.
    if (wr_en && dec_region == REGION_VRAM) vram[dec_offset[12:0]] <= cpu_wdata;
    if (rd_en) vram_rd_q <= vram[dec_offset[12:0]];
  end

  // WRAM synchronous RAM, shared with the echo window.
  always_ff @(posedge clock) begin
    if (wr_en && dec_region == REGION_WRAM) wram[dec_offset[12:0]] <= cpu_wdata;
    if (rd_en) wram_rd_q <= wram[dec_offset[12:0]];
  end

  // OAM synchronous RAM.
  always_ff @(posedge clock) begin
    if (wr_en && dec_region == REGION_OAM) oam[dec_offset[7:0]] <= cpu_wdata;
    if (rd_en) oam_rd_q <= oam[dec_offset[7:0]];
  end

  // HRAM synchronous RAM.
  always_ff @(posedge clock) begin
    if (wr_en && dec_region == REGION_HRAM) hram[dec_offset[6:0]] <= cpu_wdata;
    if (rd_en) hram_rd_q <= hram[dec_offset[6:0]];
  end

  // ------------------------------------------------- resettable register state
  logic       boot_en_q, boot_en_d;
  logic [7:0] ie_q, ie_d;
  logic [7:0] io_q [IO_SIZE];
  logic [7:0] io_d [IO_SIZE];
  region_e    region_q, region_d;
  logic       rd_valid_q, rd_valid_d;
  logic [7:0] reg_rd_q, reg_rd_d;

  assign boot_en = boot_en_q;

  // Register-file writes, boot disable, and capture of the read selection.
  always_comb begin
    boot_en_d  = boot_en;
    ie_d       = ie_q;
    io_d       = io_q;
    region_d   = region_q;
    rd_valid_d = rd_valid_q;
    reg_rd_d   = reg_rd_q;

    if (wr_en) begin
      case (dec_region)
        REGION_IO:      io_d[dec_offset[6:0]] = cpu_wdata;
        REGION_IE:      ie_d = cpu_wdata;
        REGION_BOOTOFF: if (cpu_wdata != 8'h00) boot_en_d = 1'b0;
        default:        ;
      endcase
    end

    if (rd_en) begin
      rd_valid_d = 1'b1;
      region_d   = (dec_region == REGION_BOOT && !boot_en) ? REGION_CART : dec_region;
      case (dec_region)
        REGION_IO:      reg_rd_d = io_q[dec_offset[6:0]];
        REGION_IE:      reg_rd_d = ie_q;
        REGION_BOOTOFF: reg_rd_d = boot_en ? 8'hFE : 8'hFF;
        default:        reg_rd_d = 8'hFF;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      boot_en_q  <= 1'b1;
      ie_q       <= 8'h00;
      io_q       <= '{default: 8'h00};
      region_q   <= REGION_EXT;
      rd_valid_q <= 1'b0;
      reg_rd_q   <= 8'hFF;
    end else begin
      boot_en_q  <= boot_en_d;
      ie_q       <= ie_d;
      io_q       <= io_d;
      region_q   <= region_d;
      rd_valid_q <= rd_valid_d;
      reg_rd_q   <= reg_rd_d;
    end
  end

  // Read mux on the registered region; all sources hold while rd is low.
  always_comb begin
    cpu_rdata = 8'h00;
    if (rd_valid_q) begin
      case (region_q)
        REGION_BOOT: cpu_rdata = boot_rd_q;
        REGION_CART: cpu_rdata = cart_rd_q;
        REGION_VRAM: cpu_rdata = vram_rd_q;
        REGION_WRAM: cpu_rdata = wram_rd_q;
        REGION_OAM:  cpu_rdata = oam_rd_q;
        REGION_HRAM: cpu_rdata = hram_rd_q;
        default:     cpu_rdata = reg_rd_q;
      endcase
    end
  end

endmodule

// File: tb/tb_gb_interconnect.sv
// Scoreboard bench for gb_interconnect: the bus is driven by forcing the
// internal CPU nets, a flat byte-map reference model predicts each read, and
// a monitor compares cpu_rdata/boot_en one cycle after each access.
module tb_gb_interconnect;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  gb_interconnect #(
    .BOOT_ROM_FILE (""),
    .CART_ROM_FILE ("")
  ) dut (
    .clock (clock),
    .reset (reset)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  rdata;
    logic        known;
    logic        boot_en;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Bus drive values, forced onto the internal CPU nets
  logic [15:0] drv_addr  = 16'h0000;
  logic [7:0]  drv_wdata = 8'h00;
  logic        drv_rd    = 1'b0;
  logic        drv_wr    = 1'b0;

  // Reference model: whole 64 KiB view plus ROM images and boot flag
  logic [7:0] boot_img [256];
  logic [7:0] cart_img [32768];
  logic [7:0] mem      [65536];
  bit         known    [65536];
  bit         m_boot_en = 1'b1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %02h, expected %02h", name, act, req);
    end
  endtask

  function automatic logic [15:0] canon(input logic [15:0] a);
    if (a >= 16'hE000 && a < 16'hFE00) return a - 16'h2000;
    return a;
  endfunction

  function automatic exp_t m_read(input logic [15:0] a);
    exp_t e;
    e.addr    = a;
    e.known   = 1'b1;
    e.boot_en = m_boot_en;
    e.rdata   = 8'hFF;
    if (a < 16'h0100)                          e.rdata = m_boot_en ? boot_img[a[7:0]] : cart_img[a[14:0]];
    else if (a < 16'h8000)                     e.rdata = cart_img[a[14:0]];
    else if (a >= 16'hA000 && a < 16'hC000)    e.rdata = 8'hFF;
    else if (a >= 16'hFEA0 && a < 16'hFF00)    e.rdata = 8'hFF;
    else if (a == 16'hFF50)                    e.rdata = m_boot_en ? 8'hFE : 8'hFF;
    else begin
      e.rdata = mem[canon(a)];
      e.known = known[canon(a)];
    end
    return e;
  endfunction

  task automatic m_write(input logic [15:0] a, input logic [7:0] d);
    if (a == 16'hFF50) begin
      if (d != 8'h00) m_boot_en = 1'b0;
    end else if ((a >= 16'h8000 && a < 16'hA000) || (a >= 16'hC000 && a < 16'hFEA0) ||
                 (a >= 16'hFF00)) begin
      mem[canon(a)]   = d;
      known[canon(a)] = 1'b1;
    end
  endtask

  task automatic m_reset();
    m_boot_en = 1'b1;
    for (int i = 16'hFF00; i < 16'hFF80; i++) begin
      mem[i] = 8'h00;
      known[i] = 1'b1;
    end
    mem[16'hFFFF]   = 8'h00;
    known[16'hFFFF] = 1'b1;
  endtask

  task automatic apply_bus();
    force dut.cpu_addr  = drv_addr;
    force dut.cpu_wdata = drv_wdata;
    force dut.cpu_rd    = drv_rd;
    force dut.cpu_wr    = drv_wr;
  endtask

  // One bus cycle with reset low; the expected read is queued before the write is modelled.
  task automatic bus(input logic [15:0] a, input logic [7:0] d, input logic r, input logic w);
    exp_t e;
    @(posedge clock); #1;
    reset     = 1'b0;
    drv_addr  = a;
    drv_wdata = d;
    drv_rd    = r;
    drv_wr    = w;
    apply_bus();
    e = m_read(a);
    if (w) m_write(a, d);
    if (r) begin
      e.boot_en = m_boot_en;
      exp_q.push_back(e);
    end
  endtask

  // One cycle with reset high; any concurrent access must be ignored.
  task automatic rst_cycle(input logic [15:0] a, input logic [7:0] d, input logic r, input logic w);
    @(posedge clock); #1;
    reset     = 1'b1;
    drv_addr  = a;
    drv_wdata = d;
    drv_rd    = r;
    drv_wr    = w;
    apply_bus();
    m_reset();
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 16'($urandom);
      1:       return 16'($urandom_range(0, 16'h01FF));
      2:       return 16'h8000 + 16'($urandom_range(0, 15));
      3:       return 16'hA000 + 16'($urandom_range(0, 255));
      4:       return 16'hC000 + 16'($urandom_range(0, 31));
      5:       return 16'hE000 + 16'($urandom_range(0, 31));
      6:       return 16'hFE90 + 16'($urandom_range(0, 31));
      7:       return 16'hFF00 + 16'($urandom_range(0, 16'h7F));
      8:       return 16'hFF80 + 16'($urandom_range(0, 16'h7F));
      default: return ($urandom_range(0, 1) != 0) ? 16'hFDF0 + 16'($urandom_range(0, 15))
                                                  : 16'hDDF0 + 16'($urandom_range(0, 15));
    endcase
  endfunction

  // Monitor: after each edge, compare against the reset value, the next queued read, or the held value.
  initial begin : monitor
    exp_t       e;
    logic [7:0] last = 8'h00;
    bit         last_known = 1'b1;
    bit         fire, rst_s;
    forever begin
      @(posedge clock);
      rst_s = reset;
      fire  = (dut.cpu_rd === 1'b1);
      @(negedge clock);
      if (rst_s) begin
        check("reset_rdata", dut.cpu_rdata, 8'h00);
        check("reset_boot_en", {7'd0, dut.boot_en}, 8'h01);
        last = 8'h00;
        last_known = 1'b1;
      end else if (fire) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_read: got rdata %02h, expected no read", dut.cpu_rdata);
        end else begin
          e = exp_q.pop_front();
          if (e.known) check($sformatf("read@%04h", e.addr), dut.cpu_rdata, e.rdata);
          check($sformatf("boot_en@%04h", e.addr), {7'd0, dut.boot_en}, {7'd0, e.boot_en});
          last = e.rdata;
          last_known = e.known;
        end
      end else if (last_known) begin
        check("hold_rdata", dut.cpu_rdata, last);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [15:0] a;
    int          mode;

    for (int i = 0; i < 256; i++) boot_img[i] = 8'($urandom);
    for (int i = 0; i < 32768; i++) cart_img[i] = 8'($urandom);
    boot_img[0] = cart_img[0] ^ 8'h5A;
    for (int i = 0; i < 256; i++) dut.boot_rom[i] = boot_img[i];
    for (int i = 0; i < 32768; i++) dut.cart_rom[i] = cart_img[i];
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'h00;
      known[i] = 1'b0;
    end
    apply_bus();
    m_reset();

    // Reset held two cycles, then first read of the boot ROM
    rst_cycle(16'h0000, 8'h00, 1'b1, 1'b0);
    rst_cycle(16'h0000, 8'h00, 1'b1, 1'b0);
    bus(16'h0000, 8'h00, 1'b1, 1'b0);
    bus(16'h0000, 8'h00, 1'b0, 1'b0);

    // WRAM and echo aliasing
    bus(16'hC123, 8'hA5, 1'b0, 1'b1);
    bus(16'hE123, 8'h00, 1'b1, 1'b0);
    bus(16'hE200, 8'h3C, 1'b0, 1'b1);
    bus(16'hC200, 8'h00, 1'b1, 1'b0);

    // Boot disable, then reset re-enables
    bus(16'hFF50, 8'h01, 1'b0, 1'b1);
    bus(16'h0000, 8'h00, 1'b1, 1'b0);
    bus(16'hFF50, 8'h00, 1'b1, 1'b0);
    rst_cycle(16'h0000, 8'h00, 1'b0, 1'b0);
    bus(16'h0000, 8'h00, 1'b1, 1'b0);
    bus(16'hFF50, 8'h00, 1'b1, 1'b0);

    // Read-only and unmapped regions
    bus(16'h0200, 8'h55, 1'b0, 1'b1);
    bus(16'h0200, 8'h00, 1'b1, 1'b0);
    bus(16'hA000, 8'h00, 1'b1, 1'b0);
    bus(16'hFEA0, 8'h00, 1'b1, 1'b0);

    // IE, HRAM, I/O; reset clears IE and I/O but not HRAM
    bus(16'hFFFF, 8'h1F, 1'b0, 1'b1);
    bus(16'hFF80, 8'h77, 1'b0, 1'b1);
    bus(16'hFF40, 8'h80, 1'b0, 1'b1);
    bus(16'hFFFF, 8'h00, 1'b1, 1'b0);
    bus(16'hFF80, 8'h00, 1'b1, 1'b0);
    bus(16'hFF40, 8'h00, 1'b1, 1'b0);
    rst_cycle(16'h0000, 8'h00, 1'b0, 1'b0);
    bus(16'hFFFF, 8'h00, 1'b1, 1'b0);
    bus(16'hFF40, 8'h00, 1'b1, 1'b0);
    bus(16'hFF80, 8'h00, 1'b1, 1'b0);

    // Simultaneous rd+wr returns pre-write data
    bus(16'hC000, 8'h11, 1'b0, 1'b1);
    bus(16'hC000, 8'h22, 1'b1, 1'b1);
    bus(16'hC000, 8'h00, 1'b1, 1'b0);

    // Reset overrides concurrent writes to FF50 and IE
    rst_cycle(16'hFF50, 8'h01, 1'b0, 1'b1);
    rst_cycle(16'hFFFF, 8'hAB, 1'b1, 1'b1);
    bus(16'h0000, 8'h00, 1'b1, 1'b0);
    bus(16'hFFFF, 8'h00, 1'b1, 1'b0);

    // Region boundaries back to back
    bus(16'hFE9F, 8'h6D, 1'b0, 1'b1);
    bus(16'hFE9F, 8'h00, 1'b1, 1'b0);
    bus(16'hFDFF, 8'h4E, 1'b0, 1'b1);
    bus(16'hDDFF, 8'h00, 1'b1, 1'b0);
    bus(16'h7FFF, 8'h00, 1'b1, 1'b0);
    bus(16'h00FF, 8'h00, 1'b1, 1'b0);
    bus(16'h0100, 8'h00, 1'b1, 1'b0);
    bus(16'hBFFF, 8'h00, 1'b1, 1'b0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst_cycle(rand_addr(), 8'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        a    = rand_addr();
        mode = $urandom_range(0, 3);
        bus(a, 8'($urandom), mode[0], mode[1]);
      end
    end

    repeat (3) bus(16'h0000, 8'h00, 1'b0, 1'b0);
    @(negedge clock);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d reads outstanding, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gb_interconnect.md
# gb_interconnect

System-level bus fabric of the Game Boy core: instantiates the CPU as the sole bus master and decodes its 16-bit address space onto boot ROM, cartridge ROM, VRAM, WRAM (with echo), OAM, I/O registers, HRAM and the IE register. It is the top of the synthesizable hierarchy; its only external ports are clock and reset. All bus traffic is internal and is verified through the named internal bus nets listed below.

## Interface
- BOOT_ROM_FILE, "boot.hex": hex image for the 256 B boot ROM, loaded at elaboration.
- CART_ROM_FILE, "cart.hex": hex image for the 32 KiB cartridge ROM, loaded at elaboration.
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clock.
- Internal bus nets, fixed names for probing: cpu_addr[15:0], cpu_wdata[7:0], cpu_rdata[7:0], cpu_rd, cpu_wr, boot_en.

## Operation
- Master: existing cpu core with ports clock, reset, addr, wdata, rdata, rd, wr, driven by the same clock and reset.
- Address decode, first match wins:
  - 0x0000–0x00FF: boot ROM if boot_en=1, else cartridge ROM. Read-only.
  - 0x0100–0x7FFF: cartridge ROM. Read-only; writes ignored, no MBC.
  - 0x8000–0x9FFF: VRAM, 8 KiB RW.
  - 0xA000–0xBFFF: external RAM unmapped; reads 0xFF, writes ignored.
  - 0xC000–0xDFFF: WRAM, 8 KiB RW.
  - 0xE000–0xFDFF: echo of WRAM, index = addr[12:0]; reads and writes alias 0xC000–0xDDFF.
  - 0xFE00–0xFE9F: OAM, 160 B RW.
  - 0xFEA0–0xFEFF: unusable; reads 0xFF, writes ignored.
  - 0xFF00–0xFF7F: I/O register file, 128 × 8 bit RW, reads return last written value.
  - 0xFF50: boot-disable. Write of any nonzero value clears boot_en; sticky until reset. Reads 0xFF while boot_en=0, 0xFE while boot_en=1.
  - 0xFF80–0xFFFE: HRAM, 127 B RW.
  - 0xFFFF: IE register, 8 bit RW.
- Write: when cpu_wr=1, the selected RW target updates at the rising edge with cpu_wdata.
- Read: when cpu_rd=1, the decoded byte is registered into cpu_rdata. When cpu_rd=0, cpu_rdata holds its value.
- cpu_rd and cpu_wr both 1: the write is performed. cpu_rdata returns the pre-write contents (read-before-write).
- Reset values: cpu_rdata=0x00, boot_en=1, IE=0x00, I/O file all 0x00.
- RAM contents (VRAM, WRAM, OAM, HRAM) are not cleared by reset. ROM images persist.

## Timing
- Read latency is 1 cycle. Address and rd are presented in cycle N; cpu_rdata is valid after edge N+1.
- Write latency is 1 edge. A read of the same address in the next cycle returns the new data.
- Reset asserted on an edge forces reset values that edge, overriding any concurrent write, including writes to FF50.
- Reset mid-operation clears boot_en back to 1, so boot ROM is remapped.
- No wait states; the bus accepts one access per cycle, back-to-back.

## Structure
- Shared package gb_pkg holds:
  - region base/limit localparams: BOOT_END, VRAM_BASE, EXT_BASE, WRAM_BASE, ECHO_BASE, OAM_BASE, UNUSED_BASE, IO_BASE, BOOTOFF_ADDR, HRAM_BASE, IE_ADDR;
  - the region-select enum.
- Sub-module gb_addr_decode: purely combinational addr[15:0] → region enum plus local offset, reused by future DMA/PPU ports.
- Memories are inferred synchronous arrays inside gb_interconnect. The read mux is a case on the registered region.

## Test plan
- Reset then read: hold reset 2 cycles, release, read 0x0000 → cpu_rdata equals boot ROM byte 0 one cycle later. Check boot_en=1.
- WRAM and echo: write 0xA5 to 0xC123, read 0xE123 → 0xA5. Write 0x3C to 0xE200, read 0xC200 → 0x3C.
- Boot disable: write 0x01 to 0xFF50, read 0x0000 → cartridge byte 0, read 0xFF50 → 0xFF. Assert reset, read 0x0000 → boot ROM byte 0 again.
- Read-only and unmapped regions:
  - write 0x55 to 0x0200 → read returns the original cart byte;
  - read 0xA000 and 0xFEA0 → 0xFF.
- HRAM/IE/IO: write 0x1F to 0xFFFF, 0x77 to 0xFF80, 0x80 to 0xFF40 → reads return those values. Pulse reset → IE reads 0x00, 0xFF40 reads 0x00, 0xFF80 still 0x77.
- Simultaneous rd and wr: at 0xC000 holding 0x11, apply rd+wr with data 0x22 → cpu_rdata=0x11; the next read returns 0x22.
